wb_timer: RTL and testbench

- Wishbone slave timer peripheral on the WB_InterConnect master bus (wbm_m2s), alongside Motor_Top.
- Consumes the interconnect's m2s strobe and returns ack/data to it.
- Provides a 64-bit prescaled up-counter, a 64-bit compare register and a sticky match flag.
- The match flag drives a timer interrupt line into the Core's irq bundle.

---
 rtl/timer_pkg.sv | 47 ++++
 rtl/wb_timer_if.sv | 26 ++
 rtl/wb_timer_prescaler.sv | 28 ++
 rtl/wb_timer.sv | 121 ++++++++++++
 tb/tb_wb_timer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the Wishbone timer: register map, CTRL bit layout,
// register-select decode type and the byte-lane write merge helper.
package timer_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned CTRL_W = 3;

  localparam int unsigned CTRL_EN          = 0;
  localparam int unsigned CTRL_IRQ_EN      = 1;
  localparam int unsigned CTRL_AUTO_RELOAD = 2;

  localparam logic [ADDR_W-1:0] OFF_CTRL     = 16'h0000;
  localparam logic [ADDR_W-1:0] OFF_PRESCALE = 16'h0004;
  localparam logic [ADDR_W-1:0] OFF_COUNT_LO = 16'h0008;
  localparam logic [ADDR_W-1:0] OFF_COUNT_HI = 16'h000C;
  localparam logic [ADDR_W-1:0] OFF_CMP_LO   = 16'h0010;
  localparam logic [ADDR_W-1:0] OFF_CMP_HI   = 16'h0014;
  localparam logic [ADDR_W-1:0] OFF_STATUS   = 16'h0018;
  localparam logic [ADDR_W-1:0] OFF_RSVD     = 16'h001C;

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_PRESCALE = 3'd1,
    REG_COUNT_LO = 3'd2,
    REG_COUNT_HI = 3'd3,
    REG_CMP_LO   = 3'd4,
    REG_CMP_HI   = 3'd5,
    REG_STATUS   = 3'd6,
    REG_RSVD     = 3'd7
  } reg_sel_e;

  // Replace only the byte lanes enabled in sel.
  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] wd,
                                                   input logic [SEL_W-1:0]  sel);
    logic [DATA_W-1:0] res;
    res = cur;
    for (int b = 0; b < int'(SEL_W); b++) begin
      if (sel[b]) res[8*b +: 8] = wd[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_timer_if.sv
// Wishbone slave-side bundle between the interconnect and the timer.
interface wb_timer_if;
  import timer_pkg::*;

  logic [ADDR_W-1:0] io_wbs_m2s_addr;
  logic [DATA_W-1:0] io_wbs_m2s_data;
  logic              io_wbs_m2s_we;
  logic [SEL_W-1:0]  io_wbs_m2s_sel;
  logic              io_wbs_m2s_stb;
  logic              io_ba_match;
  logic              io_wbs_ack_o;
  logic [DATA_W-1:0] io_wbs_data_o;

  modport master (
    output io_wbs_m2s_addr, io_wbs_m2s_data, io_wbs_m2s_we, io_wbs_m2s_sel,
           io_wbs_m2s_stb, io_ba_match,
    input  io_wbs_ack_o, io_wbs_data_o
  );

  modport slave (
    input  io_wbs_m2s_addr, io_wbs_m2s_data, io_wbs_m2s_we, io_wbs_m2s_sel,
           io_wbs_m2s_stb, io_ba_match,
    output io_wbs_ack_o, io_wbs_data_o
  );

endinterface

// File: rtl/wb_timer_prescaler.sv
// Prescale counter: emits a one-cycle tick every (prescale+1) enabled cycles.
module wb_timer_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick_c
);

  logic [PRESCALE_W-1:0] pre_cnt;

  assign tick_c = en & (pre_cnt == prescale);

  // A prescale rewrite restarts the period from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= tick_c ? '0 : pre_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/wb_timer.sv
// Wishbone timer: 64-bit prescaled up-counter, compare match with sticky
// pending flag, optional auto-reload and a coherent two-word count read.
module wb_timer
  import timer_pkg::*;
#(
  parameter int unsigned       PRESCALE_W = 16,
  parameter logic [CNT_W-1:0]  CMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic       clock,
  input  logic       reset,
  wb_timer_if.slave  wbs,
  output logic       io_timer_irq
);

  logic                  req, wr, rd, tick, match, pend_clr;
  reg_sel_e              reg_sel;
  logic [DATA_W-1:0]     reg_cur, rdata, wdata;
  logic                  ack;
  logic [DATA_W-1:0]     data_q;
  logic [DATA_W-1:0]     hi_shadow;
  logic [CTRL_W-1:0]     ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [CNT_W-1:0]      count, cmp;
  logic                  pending;
  logic                  unused_addr;

  assign reg_sel     = reg_sel_e'(wbs.io_wbs_m2s_addr[4:2]);
  assign unused_addr = ^{wbs.io_wbs_m2s_addr[ADDR_W-1:5], wbs.io_wbs_m2s_addr[1:0]};

  // Ack itself blocks the next request so each access costs two cycles.
  assign req      = wbs.io_wbs_m2s_stb & wbs.io_ba_match & ~ack;
  assign wr       = req & wbs.io_wbs_m2s_we & (|wbs.io_wbs_m2s_sel);
  assign rd       = req & ~wbs.io_wbs_m2s_we;
  assign pend_clr = wr & (reg_sel == REG_STATUS) & wbs.io_wbs_m2s_sel[0]
                  & wbs.io_wbs_m2s_data[0];
  assign match    = tick & (count == cmp);

  // Live register contents; COUNT_HI reads come from the shadow instead.
  always_comb begin
    reg_cur = '0;
    case (reg_sel)
      REG_CTRL:     reg_cur = DATA_W'(ctrl);
      REG_PRESCALE: reg_cur = DATA_W'(prescale);
      REG_COUNT_LO: reg_cur = count[DATA_W-1:0];
      REG_COUNT_HI: reg_cur = count[CNT_W-1:DATA_W];
      REG_CMP_LO:   reg_cur = cmp[DATA_W-1:0];
      REG_CMP_HI:   reg_cur = cmp[CNT_W-1:DATA_W];
      REG_STATUS:   reg_cur = DATA_W'(pending);
      default:      reg_cur = '0;
    endcase
  end

  assign rdata = (reg_sel == REG_COUNT_HI) ? hi_shadow : reg_cur;
  assign wdata = lane_merge(reg_cur, wbs.io_wbs_m2s_data, wbs.io_wbs_m2s_sel);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ack       <= 1'b0;
      data_q    <= '0;
      hi_shadow <= '0;
    end else begin
      ack    <= req;
      data_q <= rd ? rdata : '0;
      if (rd && reg_sel == REG_COUNT_LO) hi_shadow <= count[CNT_W-1:DATA_W];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      prescale <= '0;
      cmp      <= CMP_RST;
    end else if (wr) begin
      case (reg_sel)
        REG_CTRL:     ctrl     <= wdata[CTRL_W-1:0];
        REG_PRESCALE: prescale <= wdata[PRESCALE_W-1:0];
        REG_CMP_LO:   cmp      <= {cmp[CNT_W-1:DATA_W], wdata};
        REG_CMP_HI:   cmp      <= {wdata, cmp[DATA_W-1:0]};
        default:      ;
      endcase
    end
  end

  // Software count writes take precedence over the tick increment.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (wr && reg_sel == REG_COUNT_LO) begin
      count <= {count[CNT_W-1:DATA_W], wdata};
    end else if (wr && reg_sel == REG_COUNT_HI) begin
      count <= {wdata, count[DATA_W-1:0]};
    end else if (tick) begin
      count <= (match && ctrl[CTRL_AUTO_RELOAD]) ? '0 : count + CNT_W'(1);
    end
  end

  // A match on the same edge as a W1C keeps the flag set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
    end else if (match) begin
      pending <= 1'b1;
    end else if (pend_clr) begin
      pending <= 1'b0;
    end
  end

  wb_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .en       (ctrl[CTRL_EN]),
    .clr      (wr && reg_sel == REG_PRESCALE),
    .prescale (prescale),
    .tick_c   (tick)
  );

  assign io_timer_irq      = pending & ctrl[CTRL_IRQ_EN];
  assign wbs.io_wbs_ack_o  = ack;
  assign wbs.io_wbs_data_o = data_q;

endmodule

// File: tb/tb_wb_timer.sv
// Scoreboard bench for wb_timer against a closed-form model of the
// prescaler/counter evolution between register writes.
module tb_wb_timer;
  import timer_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic io_timer_irq;
  always #5 clock = ~clock;

  wb_timer_if bus();

  wb_timer #(.PRESCALE_W(16), .CMP_RST(64'hFFFF_FFFF_FFFF_FFFF)) dut (
    .clock        (clock),
    .reset        (reset),
    .wbs          (bus),
    .io_timer_irq (io_timer_irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  longint unsigned edge_n = 0;
  always @(posedge clock) edge_n <= edge_n + 1;

  // Model: state known exactly at edge 'anchor'; later edges derived in closed form.
  longint unsigned anchor, a_count, a_pre, m_p, m_cmp;
  bit              a_pending, m_en, m_irq_en, m_ar;
  logic [31:0]     m_hi_shadow;

  typedef struct {
    longint unsigned count;
    longint unsigned pre;
    longint unsigned nm;
  } mstate_t;

  function automatic mstate_t advance(input longint unsigned m);
    mstate_t s;
    longint unsigned n, first, c1;
    s.count = a_count; s.pre = a_pre; s.nm = 0;
    if (!m_en || m == 0) return s;
    first = m_p - a_pre + 1;
    if (m < first) begin
      n = 0; s.pre = a_pre + m;
    end else begin
      n = 1 + (m - first) / (m_p + 1);
      s.pre = (m - first) % (m_p + 1);
    end
    if (m_ar && a_count <= m_cmp) begin
      c1 = m_cmp - a_count + 1;
      s.count = (a_count + n) % (m_cmp + 1);
      s.nm = (n >= c1) ? 1 + (n - c1) / (m_cmp + 1) : 0;
    end else begin
      s.count = a_count + n;
      s.nm = (m_cmp >= a_count && m_cmp - a_count < n) ? 1 : 0;
    end
    return s;
  endfunction

  function automatic bit pend_at(input longint unsigned k);
    mstate_t s;
    s = advance(k - anchor);
    return a_pending | (s.nm != 0);
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] cur, input logic [31:0] wd,
                                         input logic [3:0] sel);
    logic [31:0] m;
    m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (cur & ~m) | (wd & m);
  endfunction

  function automatic void model_reset();
    anchor = edge_n; a_count = 0; a_pre = 0; a_pending = 0;
    m_en = 0; m_irq_en = 0; m_ar = 0; m_p = 0;
    m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_hi_shadow = '0;
  endfunction

  function automatic void model_write(input logic [15:0] addr, input logic [31:0] d,
                                      input logic [3:0] sel, input longint unsigned e);
    mstate_t sp, s;
    logic [31:0] c;
    logic [63:0] cnt;
    bit match_e;
    sp = advance(e - 1 - anchor);
    s  = advance(e - anchor);
    match_e = s.nm > sp.nm;
    a_count = s.count; a_pre = s.pre; a_pending = a_pending | (s.nm != 0); anchor = e;
    cnt = sp.count;
    if (sel != 0) begin
      case (reg_sel_e'(addr[4:2]))
        REG_CTRL: begin
          c = bmerge({29'b0, m_ar, m_irq_en, m_en}, d, sel);
          m_en = c[0]; m_irq_en = c[1]; m_ar = c[2];
        end
        REG_PRESCALE: begin
          c = bmerge(32'(m_p), d, sel);
          m_p = 64'(c[15:0]); a_pre = 0;
        end
        REG_COUNT_LO: a_count = {cnt[63:32], bmerge(cnt[31:0], d, sel)};
        REG_COUNT_HI: a_count = {bmerge(cnt[63:32], d, sel), cnt[31:0]};
        REG_CMP_LO: begin
          cnt = m_cmp; m_cmp = {cnt[63:32], bmerge(cnt[31:0], d, sel)};
        end
        REG_CMP_HI: begin
          cnt = m_cmp; m_cmp = {bmerge(cnt[63:32], d, sel), cnt[31:0]};
        end
        REG_STATUS: if (sel[0] && d[0] && !match_e) a_pending = 0;
        default: ;
      endcase
    end
  endfunction

  typedef struct {
    bit          is_read;
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t q[$];

  // Monitor: every ack must match the oldest issued access.
  always @(negedge clock) begin
    exp_t e;
    if (bus.io_wbs_ack_o) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_ack actual=1 required=0 t=%0t", $time);
      end else begin
        e = q.pop_front();
        if (e.is_read) check(e.name, bus.io_wbs_data_o, e.exp);
      end
    end else begin
      check("data_idle", bus.io_wbs_data_o, 0);
    end
  end

  task automatic check_irq();
    check("irq", io_timer_irq, pend_at(edge_n) & m_irq_en);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clock); check_irq(); end
  endtask

  task automatic drive(input logic [15:0] addr, input logic [31:0] d, input bit we,
                       input logic [3:0] sel, input bit ba);
    bus.io_wbs_m2s_addr = {11'($urandom), addr[4:2], 2'($urandom)};
    bus.io_wbs_m2s_data = d;
    bus.io_wbs_m2s_we   = we;
    bus.io_wbs_m2s_sel  = sel;
    bus.io_ba_match     = ba;
    bus.io_wbs_m2s_stb  = 1'b1;
  endtask

  task automatic release_bus();
    bus.io_wbs_m2s_stb = 1'b0;
    bus.io_ba_match    = 1'b0;
    bus.io_wbs_m2s_we  = 1'b0;
  endtask

  longint unsigned last_e;

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] d,
                           input logic [3:0] sel, input bit ba = 1'b1);
    exp_t e;
    last_e = edge_n + 1;
    if (ba) begin
      model_write(addr, d, sel, last_e);
      e.is_read = 0; e.exp = '0; e.name = "wr";
      q.push_back(e);
    end
    drive(addr, d, 1'b1, sel, ba);
    @(posedge clock);
    @(negedge clock);
    check("ack_w", bus.io_wbs_ack_o, ba);
    release_bus();
    @(negedge clock);
    check_irq();
  endtask

  task automatic bus_read(input logic [15:0] addr, input bit hold = 1'b0);
    exp_t e;
    mstate_t s;
    longint unsigned en;
    bit pend;
    en = edge_n + 1;
    s = advance(en - 1 - anchor);
    pend = a_pending | (s.nm != 0);
    e.is_read = 1;
    case (reg_sel_e'(addr[4:2]))
      REG_CTRL:     begin e.exp = {29'b0, m_ar, m_irq_en, m_en}; e.name = "rd_ctrl"; end
      REG_PRESCALE: begin e.exp = 32'(m_p); e.name = "rd_prescale"; end
      REG_COUNT_LO: begin
        e.exp = s.count[31:0]; m_hi_shadow = s.count[63:32]; e.name = "rd_count_lo";
      end
      REG_COUNT_HI: begin e.exp = m_hi_shadow; e.name = "rd_count_hi"; end
      REG_CMP_LO:   begin e.exp = m_cmp[31:0]; e.name = "rd_cmp_lo"; end
      REG_CMP_HI:   begin e.exp = m_cmp[63:32]; e.name = "rd_cmp_hi"; end
      REG_STATUS:   begin e.exp = {31'b0, pend}; e.name = "rd_status"; end
      default:      begin e.exp = '0; e.name = "rd_rsvd"; end
    endcase
    q.push_back(e);
    drive(addr, 32'($urandom), 1'b0, 4'($urandom), 1'b1);
    @(posedge clock);
    @(negedge clock);
    check("ack_r", bus.io_wbs_ack_o, 1);
    if (hold) begin
      @(negedge clock);
      check("no_second_ack", bus.io_wbs_ack_o, 0);
      release_bus();
    end else begin
      release_bus();
      @(negedge clock);
    end
    check_irq();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned t_irq;
    bit hit;
    logic [15:0] a;

    release_bus();
    bus.io_wbs_m2s_addr = '0; bus.io_wbs_m2s_data = '0; bus.io_wbs_m2s_sel = '0;
    repeat (3) @(negedge clock);
    check("rst_ack", bus.io_wbs_ack_o, 0);
    check("rst_data", bus.io_wbs_data_o, 0);
    check("rst_irq", io_timer_irq, 0);
    reset = 1'b1;
    model_reset();
    idle(2);

    // Reset values and the single-ack handshake.
    bus_read(OFF_CTRL);
    bus_read(OFF_PRESCALE);
    bus_read(OFF_COUNT_LO);
    bus_read(OFF_COUNT_HI);
    bus_read(OFF_CMP_LO);
    bus_read(OFF_CMP_HI);
    bus_read(OFF_STATUS);
    bus_read(OFF_RSVD);
    bus_read(OFF_CMP_LO, 1'b1);

    // Prescaled match: PRESCALE=3, CMP=10 -> pending after 44 cycles.
    bus_write(OFF_PRESCALE, 32'd3, 4'hF);
    bus_write(OFF_CMP_LO, 32'd10, 4'hF);
    bus_write(OFF_CMP_HI, 32'd0, 4'hF);
    bus_write(OFF_CTRL, 32'h3, 4'hF);
    t_irq = 0;
    for (int i = 0; i < 80; i++) begin
      check_irq();
      if (io_timer_irq && t_irq == 0) t_irq = edge_n;
      @(negedge clock);
    end
    check("irq_latency", t_irq - last_e, 44);
    bus_read(OFF_COUNT_LO);
    bus_read(OFF_STATUS);
    bus_write(OFF_STATUS, 32'h1, 4'h1);
    idle(3);
    bus_write(OFF_CTRL, 32'h0, 4'hF);

    // Auto-reload period of CMP+1 with random polling and clears.
    bus_write(OFF_COUNT_LO, 32'd0, 4'hF);
    bus_write(OFF_COUNT_HI, 32'd0, 4'hF);
    bus_write(OFF_PRESCALE, 32'd0, 4'hF);
    bus_write(OFF_CMP_LO, 32'd4, 4'hF);
    bus_write(OFF_STATUS, 32'h1, 4'h1);
    bus_write(OFF_CTRL, 32'h7, 4'hF);
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: bus_read(OFF_COUNT_LO);
        1: bus_read(OFF_STATUS);
        2: bus_write(OFF_STATUS, $urandom, 4'($urandom));
        default: idle($urandom_range(1, 3));
      endcase
    end

    // W1C landing on the same edge as a match tick.
    bus_write(OFF_STATUS, 32'h1, 4'h1);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (advance(edge_n + 1 - anchor).nm > advance(edge_n - anchor).nm) begin
        bus_write(OFF_STATUS, 32'h1, 4'h1);
        hit = 1;
      end else begin
        @(negedge clock);
        check_irq();
      end
    end
    if (hit) check("sticky_irq", io_timer_irq, 1);
    else begin
      checks++; errors++;
      $display("FAIL sticky_window actual=none required=match_edge");
    end
    bus_read(OFF_STATUS);
    bus_write(OFF_CTRL, 32'h0, 4'hF);

    // Coherent 64-bit read across a low-word carry.
    bus_write(OFF_CMP_LO, 32'hFFFF_FFFF, 4'hF);
    bus_write(OFF_CMP_HI, 32'hFFFF_FFFF, 4'hF);
    bus_write(OFF_COUNT_LO, 32'hFFFF_FFFF - 32'($urandom_range(0, 10)), 4'hF);
    bus_write(OFF_COUNT_HI, 32'd0, 4'hF);
    bus_write(OFF_STATUS, 32'h1, 4'h1);
    bus_write(OFF_CTRL, 32'h1, 4'hF);
    for (int i = 0; i < 8; i++) begin
      bus_read(OFF_COUNT_LO);
      idle($urandom_range(0, 3));
      bus_read(OFF_COUNT_HI);
    end
    bus_write(OFF_CTRL, 32'h0, 4'hF);

    // Byte lanes, base-address qualification and sel=0.
    bus_write(OFF_CMP_LO, 32'h1122_3344, 4'hF);
    bus_write(OFF_CMP_LO, 32'hAABB_CCDD, 4'b0010);
    bus_read(OFF_CMP_LO);
    bus_write(OFF_CMP_LO, 32'h0, 4'hF, 1'b0);
    bus_read(OFF_CMP_LO);
    bus_write(OFF_CMP_HI, $urandom, 4'h0);
    bus_read(OFF_CMP_HI);
    bus_write(OFF_RSVD, $urandom, 4'hF);
    bus_read(OFF_RSVD);
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0: a = OFF_CMP_LO;
        1: a = OFF_CMP_HI;
        default: a = OFF_PRESCALE;
      endcase
      bus_write(a, $urandom, 4'($urandom));
      bus_read(a);
    end

    // Reset asserted during an acked write.
    bus_write(OFF_CMP_LO, 32'd0, 4'hF);
    bus_write(OFF_CMP_HI, 32'd0, 4'hF);
    bus_write(OFF_COUNT_LO, 32'd0, 4'hF);
    bus_write(OFF_COUNT_HI, 32'd0, 4'hF);
    bus_write(OFF_PRESCALE, 32'd0, 4'hF);
    bus_write(OFF_CTRL, 32'h3, 4'hF);
    idle(3);
    check("pre_rst_irq", io_timer_irq, 1);
    drive(OFF_CTRL, 32'h7, 1'b1, 4'hF, 1'b1);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("midrst_ack", bus.io_wbs_ack_o, 0);
    check("midrst_irq", io_timer_irq, 0);
    check("midrst_data", bus.io_wbs_data_o, 0);
    @(negedge clock);
    release_bus();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    model_reset();
    idle(1);
    bus_read(OFF_CTRL);
    bus_read(OFF_STATUS);
    bus_read(OFF_COUNT_LO);
    bus_read(OFF_CMP_LO);
    bus_read(OFF_PRESCALE);

    idle(2);
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
